// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding, result constants, FSM states
// and small helpers that classify an op code.
package alu_pkg;

    localparam int RESULT_W = 16;
    localparam logic [RESULT_W-1:0] ILLEGAL_RESULT = 16'hDEAD;

    // Counter load for the single-cycle ops: they complete on the first EXEC edge.
    localparam logic [3:0] ALU_CNT_LOAD = 4'd0;

    typedef enum logic [2:0] {
        no_op  = 3'd0,
        add_op = 3'd1,
        and_op = 3'd2,
        xor_op = 3'd3,
        mul_op = 3'd4,
        rst_op = 3'd7
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE,
        WAIT_LOW
    } alu_state_t;

    // Ops that start a real computation.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == add_op) || (op == and_op) || (op == xor_op) || (op == mul_op);
    endfunction

    // Codes 5 and 6 have no operation assigned.
    function automatic logic is_unused_op(input logic [2:0] op);
        return (op == 3'd5) || (op == 3'd6);
    endfunction

endpackage

// File: rtl/alu_mul_pipe.sv
// Registered unsigned multiplier, LAT stages deep. valid_out follows
// valid_in by exactly LAT clock edges, alongside the matching product.
module alu_mul_pipe #(
    parameter int DATA_W = 8,
    parameter int LAT    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  valid_out,
    output logic [2*DATA_W-1:0]   product
);

    logic [LAT-1:0]      vld_q;
    logic [2*DATA_W-1:0] prod_q [LAT];
    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;

    assign a_ext = {{DATA_W{1'b0}}, a};
    assign b_ext = {{DATA_W{1'b0}}, b};

    // Valid chain: cleared by reset so an aborted multiply never completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[LAT-2:0], valid_in};
        end
    end

    // Product data path.
    // NOTE: data stages carry no reset; only the valid bits decide whether
    // a stage means anything, so resetting the data would add nothing.
    always_ff @(posedge clk) begin
        prod_q[0] <= a_ext * b_ext;
        for (int i = 1; i < LAT; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign valid_out = vld_q[LAT-1];
    assign product   = prod_q[LAT-1];

endmodule

// File: rtl/alu_core.sv
// Multi-cycle ALU, responder side of the start/done handshake.
// Captures op/A/B on start, computes, and returns the result with a
// one-cycle done pulse. Multiplies go through alu_mul_pipe.
// Optional feature macro: ALU_CORE_ERR_EN adds the err port and turns the
// unused op codes 5/6 into single-cycle ops returning ILLEGAL_RESULT.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [DATA_W-1:0]     A,
    input  logic [DATA_W-1:0]     B,
    output logic                  done,
    output logic [2*DATA_W-1:0]   result
`ifdef ALU_CORE_ERR_EN
    ,
    output logic                  err
`endif
);

    alu_state_t          state;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [3:0]          cnt;

    logic                accept;
    logic                mul_launch;
    logic                mul_valid;
    logic [2*DATA_W-1:0] mul_product;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] alu_value;
    logic                exec_finish;

`ifdef ALU_CORE_ERR_EN
    assign accept = start && (is_legal_op(op) || is_unused_op(op));
`else
    assign accept = start && is_legal_op(op);
`endif

    // The multiplier samples the live operands on the same edge the core captures them.
    assign mul_launch = (state == IDLE) && start && (op == mul_op);

    alu_mul_pipe #(
        .DATA_W (DATA_W),
        .LAT    (MUL_LAT)
    ) u_mul_pipe (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (mul_launch),
        .a         (A),
        .b         (B),
        .valid_out (mul_valid),
        .product   (mul_product)
    );

    assign sum         = {1'b0, a_q} + {1'b0, b_q};
    assign exec_finish = (op_q == mul_op) ? mul_valid : (cnt == '0);

    // Result selection from the captured operation and operands.
    always_comb begin
        // NOTE: default assignment first so no path leaves alu_value unassigned (no latch).
        alu_value = '0;
        case (op_q)
            add_op:  alu_value = {{(DATA_W-1){1'b0}}, sum};
            and_op:  alu_value = {{DATA_W{1'b0}}, a_q & b_q};
            xor_op:  alu_value = {{DATA_W{1'b0}}, a_q ^ b_q};
            mul_op:  alu_value = mul_product;
            default: alu_value = (2*DATA_W)'(ILLEGAL_RESULT);
        endcase
    end

    // Handshake FSM with registered done/result/err.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= no_op;
            a_q    <= '0;
            b_q    <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
`ifdef ALU_CORE_ERR_EN
            err    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            done <= 1'b0;
`ifdef ALU_CORE_ERR_EN
            err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q  <= op;
                        a_q   <= A;
                        b_q   <= B;
                        cnt   <= ALU_CNT_LOAD;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_finish) begin
                        result <= alu_value;
                        done   <= 1'b1;
`ifdef ALU_CORE_ERR_EN
                        err    <= is_unused_op(op_q);
`endif
                        state  <= DONE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= start ? WAIT_LOW : IDLE;
                end
                WAIT_LOW: begin
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Testbench for alu_core: directed scenarios plus randomized ops, all
// checked every cycle against a transaction-level model of the ALU.
module tb_alu_core;

    localparam int MUL_LAT = 3;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        done;
    logic [15:0] result;
`ifdef ALU_CORE_ERR_EN
    logic        err;
`endif

    alu_core #(
        .DATA_W  (8),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .done   (done),
        .result (result)
`ifdef ALU_CORE_ERR_EN
        ,
        .err    (err)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_done_cyc = -1;
    int n_done_exp = 0;
    int n_done_seen = 0;
    logic [15:0] exp_res = 16'h0000;
    logic [15:0] pend_res = 16'h0000;
    logic        pend_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: what an op returns, whether it is accepted, how long it takes.
    function automatic logic [15:0] model_res(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int ai = int'(a);
        int bi = int'(b);
        case (o)
            3'd1:    return 16'(ai + bi);
            3'd2:    return {8'h00, a & b};
            3'd3:    return {8'h00, a ^ b};
            3'd4:    return 16'(ai * bi);
            default: return 16'hDEAD;
        endcase
    endfunction

    function automatic bit model_accepts(input logic [2:0] o);
`ifdef ALU_CORE_ERR_EN
        return (o >= 3'd1) && (o <= 3'd6);
`else
        return (o >= 3'd1) && (o <= 3'd4);
`endif
    endfunction

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        bit exp_done;
        forever begin
            @(negedge clk);
            exp_done = (cyc == exp_done_cyc) && !reset;
            if (exp_done) begin
                exp_res = pend_res;
                n_done_exp++;
            end
            if (done === 1'b1) n_done_seen++;
            check("done", done, exp_done);
            check("result", result, exp_res);
`ifdef ALU_CORE_ERR_EN
            check("err", err, exp_done ? pend_err : 1'b0);
`endif
        end
    end

    // One requester transaction; accepted ops wait for done then hold start 'hold' extra cycles.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b, input int hold);
        int waited;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (model_accepts(o)) begin
            pend_res     = model_res(o, a, b);
            pend_err     = (o == 3'd5) || (o == 3'd6);
            exp_done_cyc = cyc + 1 + ((o == 3'd4) ? MUL_LAT : 1);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
                A  = 8'($urandom);
                B  = 8'($urandom);
                op = 3'($urandom);
            end while (done !== 1'b1 && waited < 40);
            if (done !== 1'b1) check("done_timeout", done, 1'b1);
            repeat (hold) @(negedge clk);
            start = 1'b0;
        end else begin
            repeat (hold + 1) @(negedge clk);
            start = 1'b0;
        end
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = 8'h00;
        B     = 8'h00;
        #1;
        check("reset_done", done, 1'b0);
        check("reset_result", result, 16'h0000);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;

        // 1: add with carry out
        run_op(3'd1, 8'hFF, 8'h01, 0);
        check("t1_add", result, 16'h0100);

        // 2: multiply, operands toggled during EXEC by run_op
        run_op(3'd4, 8'hFF, 8'hFF, 0);
        check("t2_mul", result, 16'hFE01);

        // 3: back-to-back xor then and, start held after the second done
        d0 = n_done_seen;
        run_op(3'd3, 8'hA5, 8'h0F, 0);
        check("t3_xor", result, 16'h00AA);
        run_op(3'd2, 8'hF0, 8'h3C, 2);
        check("t3_and", result, 16'h0030);
        repeat (3) @(negedge clk);
        check("t3_done_pulses", 32'(n_done_seen - d0), 32'd2);

        // 4: no_op and rst_op are ignored
        run_op(3'd0, 8'h12, 8'h34, 0);
        run_op(3'd7, 8'h56, 8'h78, 1);
        repeat (2) @(negedge clk);
        check("t4_hold", result, 16'h0030);

        // 5: reset in the middle of a multiply
        @(negedge clk);
        start = 1'b1;
        op    = 3'd4;
        A     = 8'hC3;
        B     = 8'h5A;
        exp_done_cyc = cyc + 1 + MUL_LAT;
        pend_res = model_res(3'd4, 8'hC3, 8'h5A);
        pend_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_res = 16'h0000;
        exp_done_cyc = -1;
        start = 1'b0;
        #1;
        check("t5_rst_done", done, 1'b0);
        check("t5_rst_result", result, 16'h0000);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        repeat (10) @(negedge clk);
        run_op(3'd1, 8'h03, 8'h04, 0);
        check("t5_add", result, 16'h0007);

        // 6: unused op code 5
`ifdef ALU_CORE_ERR_EN
        run_op(3'd5, 8'h01, 8'h02, 0);
        check("t6_illegal", result, 16'hDEAD);
`else
        run_op(3'd5, 8'h01, 8'h02, 19);
        check("t6_ignored", result, 16'h0007);
`endif

        // Randomized ops with random post-done hold
        for (int i = 0; i < 150; i++) begin
            run_op(3'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        repeat (5) @(negedge clk);
        check("done_count", n_done_seen, n_done_exp);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
